truth_table_checker: RTL and testbench
======================================

Name: truth_table_checker

Overview:
- Sequential self-checking sweep engine for the 4-input boolean function F = (AB' + A'B)(C + D').
- Sits on the opposite side of the function under test: drives all 16 input vectors and samples the function's output F for each vector.
- Compares each sample with a golden truth table and reports pass/fail, mismatch count and first failing index.
- Replaces manual waveform inspection of the sweep with an in-hardware verdict.

Parameters:
- SETTLE_CYCLES, 2: clock edges each vector is held before F is sampled; legal range 1..15.
- GOLDEN, 16'h0DD0: expected F per vector index {A,B,C,D}; bit i = F(i); ones at indices 4,6,7,8,10,11.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; ignored while busy=1.
- dut_f  in  1  output F of the function under test.
- vec_out  out  4  vector applied to the function: [3]=A, [2]=B, [1]=C, [0]=D.
- busy  out  1  sweep in progress.
- done  out  1  level; sweep finished, held until next accepted start or rst.
- pass  out  1  valid when done=1; 1 iff err_count==0.
- err_count  out  5  number of mismatching vectors, 0..16.
- first_err_idx  out  4  index of first mismatching vector.
- first_err_valid  out  1  at least one mismatch recorded this sweep.

Behaviour:
- Clock/reset are decided: one clock, clk; reset rst is asynchronous and active-high.
- rst=1 forces every output and register to 0 immediately:
  - state=IDLE, vec_out=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, first_err_valid=0, settle counter=0.
- States:
  - IDLE: outputs static; start=1 -> RUN.
  - RUN: sweeping; exits to DONE after the index-15 sample.
  - DONE: start=1 -> RUN.
- Start acceptance (IDLE or DONE, start=1), at that edge:
  - vec_out=0, busy=1, done=0, pass=0, err_count=0, first_err_valid=0, first_err_idx=0, settle counter=0.
- RUN, each edge:
  - If counter < SETTLE_CYCLES-1: counter increments; vec_out is held.
  - Else: sample dut_f and compare with GOLDEN[vec_out].
  - On mismatch, in the same edge: err_count+1; if first_err_valid=0, capture first_err_idx=vec_out and set first_err_valid=1.
  - If vec_out<15: vec_out+1, counter=0.
  - If vec_out==15: go to DONE; busy=0, done=1, pass=(final err_count==0), vec_out stays 15.
- Latency: done rises exactly 16*SETTLE_CYCLES edges after the start-accepting edge.
- Each vector is stable for exactly SETTLE_CYCLES cycles before its sampling edge.
- Width rules:
  - err_count is 5 bits so 16 mismatches cannot wrap.
  - vec_out is never incremented past 15; no wrap to 0 inside a sweep.
- start while busy=1 is ignored; the sweep is not restarted.
- start coincident with the final sample edge is ignored; done still rises.
- In DONE, start=1 restarts; done drops in the accepting edge.
- rst mid-sweep aborts immediately to the reset values; a new start is required.
- dut_f is sampled only at sampling edges; glitches between sampling edges are irrelevant.

Optional Feature:
- Macro: TTC_STOP_ON_FIRST_ERR_EN
- Defined: the first mismatch ends the sweep at that sampling edge.
  - Go to DONE with done=1, pass=0, err_count=1, first_err_idx set, first_err_valid=1.
  - vec_out holds the failing index.
- Undefined: all 16 vectors are always swept as above.

Decomposition:
- Package ttc_pkg:
  - state enum {IDLE, RUN, DONE}.
  - NUM_VECTORS=16.
  - Default GOLDEN constant 16'h0DD0.
  - Width constants VEC_W=4, CNT_W=5.
- One natural sub-module, ttc_settle_timer:
  - Counter with clear and a terminal-count pulse at SETTLE_CYCLES-1.
  - Instantiated once; the FSM stays in truth_table_checker.

Test Plan:
- Reset then start, dut_f driven by a correct model of F, SETTLE_CYCLES=2:
  - done at edge 32 after start, pass=1, err_count=0, first_err_valid=0, vec_out=15.
- Model with F forced to 0 for vector 6 only:
  - pass=0, err_count=1, first_err_idx=6, first_err_valid=1.
- dut_f tied to 1:
  - err_count=10, first_err_idx=0.
- dut_f tied to 0:
  - err_count=6, first_err_idx=4.
- Assert rst at vector 9 mid-sweep:
  - All outputs 0 in the same cycle.
- Pulse start at vector 5 mid-sweep:
  - Ignored; done still rises at edge 32.
- SETTLE_CYCLES=1, correct model:
  - done at edge 16, pass=1.
- Immediate restart from DONE:
  - Counters cleared; second sweep passes.
- With TTC_STOP_ON_FIRST_ERR_EN and the vector-6 fault:
  - done at edge 14, err_count=1, vec_out=6.

Source files
------------

// File: rtl/ttc_pkg.sv
// Shared types and constants for the truth-table sweep checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, vector count, default golden table for
// F = (AB' + A'B)(C + D'), and the vector / settle-counter widths.
package ttc_pkg;

    localparam int unsigned NUM_VECTORS = 16;
    localparam int unsigned VEC_W       = 4;
    localparam int unsigned CNT_W       = 5;

    // Bit i holds F for vector index i = {A,B,C,D}; ones at 4,6,7,8,10,11.
    localparam logic [NUM_VECTORS-1:0] GOLDEN_DEFAULT = 16'h0DD0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ttc_state_e;

endpackage : ttc_pkg

// File: rtl/ttc_settle_timer.sv
// Settle timer: counts the cycles a vector is held and flags the sampling cycle.
// Latency: tc_o is combinational from the count register (high when count == SETTLE_CYCLES-1).
// Backpressure: none; counts only while en_i is high, clr_i has priority.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   clr_i    in   synchronous clear to 0 (sweep start)
//   en_i     in   count enable (sweep running)
//   tc_o     out  terminal count: this edge is a sampling edge
module ttc_settle_timer
    import ttc_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o = (cnt_q == TC_VAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            // Wrap to zero on the sampling edge so the next vector starts fresh.
            cnt_d = tc_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : ttc_settle_timer

// File: rtl/truth_table_checker.sv
// Sweeps all 16 input vectors of F = (AB' + A'B)(C + D') and checks sampled F against a golden table.
// Latency: done rises 16*SETTLE_CYCLES edges after the start-accepting edge.
// Backpressure: start is ignored while busy; no other flow control.
//
// Optional build macro TTC_STOP_ON_FIRST_ERR_EN: when defined, the first
// mismatch ends the sweep at its sampling edge with vec_out holding the
// failing index. When undefined, all 16 vectors are always swept.
//
// Ports:
//   clk              in   clock, rising edge
//   rst              in   asynchronous active-high reset
//   start            in   one-cycle sweep request (accepted in IDLE/DONE)
//   dut_f            in   output F of the function under test
//   vec_out[3:0]     out  applied vector {A,B,C,D}
//   busy             out  sweep in progress
//   done             out  sweep finished (level, until next start or reset)
//   pass             out  valid with done; 1 iff err_count == 0
//   err_count[4:0]   out  mismatching vectors this sweep, 0..16
//   first_err_idx    out  index of first mismatch
//   first_err_valid  out  at least one mismatch recorded
module truth_table_checker
    import ttc_pkg::*;
#(
    parameter int unsigned             SETTLE_CYCLES = 2,
    parameter logic [NUM_VECTORS-1:0]  GOLDEN        = GOLDEN_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dut_f,
    output logic [VEC_W-1:0] vec_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [VEC_W-1:0] first_err_idx,
    output logic             first_err_valid
);

    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);

    ttc_state_e       state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [VEC_W-1:0] fei_q, fei_d;
    logic             fev_q, fev_d;

    logic             start_acc;
    logic             sample_tc;
    logic             mismatch;
    logic [CNT_W-1:0] err_inc;

    ttc_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (start_acc),
        .en_i  (state_q == ST_RUN),
        .tc_o  (sample_tc)
    );

    // Compare only matters on sampling edges; between them dut_f is ignored.
    assign mismatch = (dut_f != GOLDEN[vec_q]);
    assign err_inc  = err_q + CNT_W'(mismatch);

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        err_d     = err_q;
        fei_d     = fei_q;
        fev_d     = fev_q;
        start_acc = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = ST_RUN;
                    vec_d     = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    err_d     = '0;
                    fei_d     = '0;
                    fev_d     = 1'b0;
                end
            end

            ST_RUN: begin
                if (sample_tc) begin
                    if (mismatch) begin
                        err_d = err_inc;
                        if (!fev_q) begin
                            fei_d = vec_q;
                            fev_d = 1'b1;
                        end
                    end
`ifdef TTC_STOP_ON_FIRST_ERR_EN
                    if (mismatch || (vec_q == LAST_VEC)) begin
                        // vec_out is left on the failing (or last) index.
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = !mismatch && (err_q == '0);
                    end else begin
                        vec_d = vec_q + VEC_W'(1);
                    end
`else
                    if (vec_q == LAST_VEC) begin
                        // vec_out stays at 15; no wrap inside a sweep.
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        vec_d = vec_q + VEC_W'(1);
                    end
`endif
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fei_q   <= '0;
            fev_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fei_q   <= fei_d;
            fev_q   <= fev_d;
        end
    end

    assign vec_out         = vec_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_idx   = fei_q;
    assign first_err_valid = fev_q;

endmodule : truth_table_checker

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: two instances (SETTLE_CYCLES=2 and =1) driven
// by a model of F with a per-vector fault mask; expected results come from the
// boolean formula and the mask.
module tb_truth_table_checker;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic sel;
    logic [15:0] mask;

    always #5 clk = ~clk;

    logic       start_a, start_b, dut_f_a, dut_f_b;
    logic [3:0] vec_a, vec_b, fei_a, fei_b;
    logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b, fev_a, fev_b;
    logic [4:0] err_a, err_b;

    int checks = 0;
    int failures = 0;

    function automatic logic ref_f(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return (a ^ b) & (c | ~d);
    endfunction

    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign dut_f_a = ref_f(vec_a) ^ mask[vec_a];
    assign dut_f_b = ref_f(vec_b) ^ mask[vec_b];

    truth_table_checker #(.SETTLE_CYCLES(2)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .dut_f(dut_f_a),
        .vec_out(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_err_idx(fei_a), .first_err_valid(fev_a)
    );

    truth_table_checker #(.SETTLE_CYCLES(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .dut_f(dut_f_b),
        .vec_out(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_err_idx(fei_b), .first_err_valid(fev_b)
    );

    // Selected-instance view.
    wire [3:0] o_vec  = sel ? vec_b  : vec_a;
    wire       o_busy = sel ? busy_b : busy_a;
    wire       o_done = sel ? done_b : done_a;
    wire       o_pass = sel ? pass_b : pass_a;
    wire [4:0] o_err  = sel ? err_b  : err_a;
    wire [3:0] o_fei  = sel ? fei_b  : fei_a;
    wire       o_fev  = sel ? fev_b  : fev_a;

    function automatic logic [15:0] golden_table();
        logic [15:0] g;
        for (int i = 0; i < 16; i++) g[i] = ref_f(4'(i));
        return g;
    endfunction

    // Run one sweep on the selected instance and compare against the model.
    //   mid_vec  : >=0 pulses start once while that vector is applied
    //   pulse_last: pulses start coincident with the final sample edge
    task automatic run_sweep(input bit which, input logic [15:0] m, input int mid_vec,
                             input bit pulse_last, input string nm);
        int s, n, exp_edge, exp_err, exp_first, exp_vec;
        bit seen, pulsed, exp_fev, exp_pass;
        s = which ? 1 : 2;
        exp_err = 0; exp_first = 0; exp_fev = 0;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                if (!exp_fev) exp_first = i;
                exp_fev = 1;
                exp_err++;
            end
        end
        exp_edge = 16 * s;
        exp_vec  = 15;
`ifdef TTC_STOP_ON_FIRST_ERR_EN
        if (exp_fev) begin
            exp_err  = 1;
            exp_edge = (exp_first + 1) * s;
            exp_vec  = exp_first;
        end
`endif
        exp_pass = (exp_err == 0);

        @(negedge clk);
        sel = which; mask = m; start = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (o_busy !== 1'b1 || o_done !== 1'b0 || o_err !== 5'd0 || o_fev !== 1'b0 || o_vec !== 4'd0) begin
            failures++;
            $display("FAIL %s accept: busy=%b done=%b err=%0d fev=%b vec=%0d, want busy=1 done=0 err=0 fev=0 vec=0",
                     nm, o_busy, o_done, o_err, o_fev, o_vec);
        end
        n = 0; seen = 0; pulsed = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            start = 1'b0;
            if (mid_vec >= 0 && !pulsed && o_vec == 4'(mid_vec)) begin
                start = 1'b1; pulsed = 1;
            end
            if (pulse_last && n == exp_edge - 1) start = 1'b1;
            @(posedge clk); n++;
            #1;
            if (o_done) seen = 1;
        end
        start = 1'b0;
        checks++;
        if (!seen || n != exp_edge) begin
            failures++;
            $display("FAIL %s done_edge: got %0d (seen=%b), want %0d", nm, n, seen, exp_edge);
        end
        checks++;
        if (o_pass !== exp_pass || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s pass/busy: pass=%b busy=%b, want pass=%b busy=0", nm, o_pass, o_busy, exp_pass);
        end
        checks++;
        if (o_err !== 5'(exp_err)) begin
            failures++;
            $display("FAIL %s err_count: got %0d, want %0d", nm, o_err, exp_err);
        end
        checks++;
        if (o_fev !== exp_fev || o_fei !== 4'(exp_first)) begin
            failures++;
            $display("FAIL %s first_err: valid=%b idx=%0d, want valid=%b idx=%0d",
                     nm, o_fev, o_fei, exp_fev, exp_first);
        end
        checks++;
        if (o_vec !== 4'(exp_vec)) begin
            failures++;
            $display("FAIL %s vec_out: got %0d, want %0d", nm, o_vec, exp_vec);
        end
        if (pulse_last) begin
            @(posedge clk); #1;
            checks++;
            if (o_done !== 1'b1 || o_busy !== 1'b0) begin
                failures++;
                $display("FAIL %s last_start_ignored: done=%b busy=%b, want done=1 busy=0", nm, o_done, o_busy);
            end
        end
    endtask

    task automatic check_all_zero(input string nm);
        checks++;
        if ({vec_a, busy_a, done_a, pass_a, err_a, fei_a, fev_a} !== 17'd0 ||
            {vec_b, busy_b, done_b, pass_b, err_b, fei_b, fev_b} !== 17'd0) begin
            failures++;
            $display("FAIL %s: a={vec=%0d busy=%b done=%b pass=%b err=%0d fei=%0d fev=%b} b_busy=%b b_done=%b, want all 0",
                     nm, vec_a, busy_a, done_a, pass_a, err_a, fei_a, fev_a, busy_b, done_b);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sel = 1'b0; mask = '0;
        #12;
        check_all_zero("reset_values");
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_correct();
        run_sweep(1'b0, 16'h0000, -1, 1'b0, "correct_s2");
    endtask

    task automatic test_single_fault();
        run_sweep(1'b0, 16'h0040, -1, 1'b0, "fault_vec6");
    endtask

    task automatic test_tied();
        logic [15:0] g;
        g = golden_table();
        run_sweep(1'b0, ~g, -1, 1'b0, "tied_one");
        run_sweep(1'b0, g, -1, 1'b0, "tied_zero");
    endtask

    task automatic test_mid_start();
        run_sweep(1'b0, 16'h0000, 5, 1'b0, "mid_start_ignored");
    endtask

    task automatic test_start_on_last();
        run_sweep(1'b0, 16'h0000, -1, 1'b1, "start_on_last_edge");
    endtask

    task automatic test_settle1();
        run_sweep(1'b1, 16'h0000, -1, 1'b0, "correct_s1");
        run_sweep(1'b1, 16'h0040, -1, 1'b0, "fault_s1");
    endtask

    task automatic test_back_to_back();
        run_sweep(1'b0, 16'h8421, -1, 1'b0, "b2b_first");
        run_sweep(1'b0, 16'h0000, -1, 1'b0, "b2b_restart");
    endtask

    task automatic test_mid_reset();
        int k;
        @(negedge clk);
        sel = 1'b0; mask = '0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0;
        while (vec_a != 4'd9 && k < 100) begin
            @(negedge clk); k++;
        end
        checks++;
        if (vec_a !== 4'd9 || busy_a !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_reach9: vec=%0d busy=%b, want vec=9 busy=1", vec_a, busy_a);
        end
        #2 rst = 1'b1;
        #1 check_all_zero("mid_reset_immediate");
        @(negedge clk); rst = 1'b0;
        repeat (4) @(negedge clk);
        check_all_zero("mid_reset_stays_idle");
    endtask

    task automatic test_random();
        logic [15:0] m;
        bit w;
        for (int t = 0; t < 8; t++) begin
            m = 16'($urandom);
            if (t == 0) m = '0;
            if (t == 1) m = 16'hFFFF;
            w = 1'($urandom_range(0, 1));
            run_sweep(w, m, -1, 1'b0, $sformatf("random_%0d", t));
        end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_single_fault();
        test_tied();
        test_mid_start();
        test_start_on_last();
        test_settle1();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_truth_table_checker
